// File: rtl/cache_nwsa_pkg.sv
// rtl/cache_nwsa_pkg.sv - shared FSM type and address-split width helpers for cache_nwsa
package cache_nwsa_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2
  } state_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set true-LRU age array with touch port and victim select
module cache_lru
  import cache_nwsa_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = index_w(SETS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             touch_i,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic [SET_W-1:0] set_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way_i)
          age_q[touch_set_i][w] <= '0;
        else if (age_q[touch_set_i][w] < age_q[touch_set_i][touch_way_i])
          age_q[touch_set_i][w] <= age_q[touch_set_i][w] + 1'b1;
      end
    end
  end

  // Descending scans so the lowest-numbered match wins; an invalid way beats the oldest.
  always_comb begin
    victim_o = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[set_i][w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) victim_o = WAY_W'(w);
  end

endmodule

// File: rtl/cache_nwsa.sv
// rtl/cache_nwsa.sv - N-way set-associative write-back write-allocate cache controller
module cache_nwsa
  import cache_nwsa_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int WAYS       = 4,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic              rd_cpu,
  input  logic              wr_cpu,
  input  logic [DATA_W-1:0] data_in_cpu,
  output logic [DATA_W-1:0] data_out_cpu,
  output logic              stall_cpu,
  output logic [ADDR_W-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] data_mem_out,
  input  logic [DATA_W-1:0] data_mem_in,
  input  logic              ready_mem
);

  localparam int OFF_W = offset_w(LINE_WORDS);
  localparam int IDX_W = index_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W = $clog2(WAYS);

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  assign {req_tag, req_idx, req_off} = addr_cpu;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][LINE_WORDS];

  state_t            state_q;
  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  cnt_q;
  logic [OFF_W-1:0]  cnt_d;
  logic              last_beat;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              touch;

  assign req       = rd_cpu | wr_cpu;
  assign cnt_d     = cnt_q + 1'b1;
  assign last_beat = &cnt_q;
  assign touch     = (state_q == S_IDLE) && req && hit;
  assign stall_cpu = (state_q != S_IDLE) || (req && !hit);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clock       (clock),
    .reset       (reset),
    .touch_i     (touch),
    .touch_set_i (req_idx),
    .touch_way_i (hit_way),
    .set_i       (req_idx),
    .valid_i     (valid_q[req_idx]),
    .victim_o    (victim)
  );

  // The request is held stable while stalled, so addr_cpu supplies tag/index for every beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      victim_q     <= '0;
      cnt_q        <= '0;
      data_out_cpu <= '0;
      rd_mem       <= 1'b0;
      wr_mem       <= 1'b0;
      addr_mem     <= '0;
      data_mem_out <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && hit) begin
            if (wr_cpu) dirty_q[req_idx][hit_way] <= 1'b1;
            else        data_out_cpu <= data_q[req_idx][hit_way][req_off];
          end else if (req) begin
            victim_q <= victim;
            cnt_q    <= '0;
            if (dirty_q[req_idx][victim]) begin
              state_q      <= S_WRITEBACK;
              wr_mem       <= 1'b1;
              addr_mem     <= {tag_q[req_idx][victim], req_idx, OFF_W'(0)};
              data_mem_out <= data_q[req_idx][victim][0];
            end else begin
              state_q  <= S_REFILL;
              rd_mem   <= 1'b1;
              addr_mem <= {req_tag, req_idx, OFF_W'(0)};
            end
          end
        end
        S_WRITEBACK: begin
          if (ready_mem) begin
            if (last_beat) begin
              state_q                    <= S_REFILL;
              wr_mem                     <= 1'b0;
              rd_mem                     <= 1'b1;
              cnt_q                      <= '0;
              dirty_q[req_idx][victim_q] <= 1'b0;
              addr_mem                   <= {req_tag, req_idx, OFF_W'(0)};
            end else begin
              cnt_q        <= cnt_d;
              addr_mem     <= {tag_q[req_idx][victim_q], req_idx, cnt_d};
              data_mem_out <= data_q[req_idx][victim_q][cnt_d];
            end
          end
        end
        S_REFILL: begin
          if (ready_mem) begin
            if (last_beat) begin
              state_q                    <= S_IDLE;
              rd_mem                     <= 1'b0;
              tag_q[req_idx][victim_q]   <= req_tag;
              valid_q[req_idx][victim_q] <= 1'b1;
              dirty_q[req_idx][victim_q] <= 1'b0;
            end else begin
              cnt_q    <= cnt_d;
              addr_mem <= {req_tag, req_idx, cnt_d};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (touch && wr_cpu)
        data_q[req_idx][hit_way][req_off] <= data_in_cpu;
      else if ((state_q == S_REFILL) && ready_mem)
        data_q[req_idx][victim_q][cnt_q] <= data_mem_in;
    end
  end

endmodule
